// File: rtl/filter_bank.sv
// filter_bank: cascade of one-pole low-pass IIR stages sharing one multiplier, with a Wishbone-classic register window.
// Optional macro FILTER_BANK_PEAK_EN adds a read-only, clear-on-read PEAK register after the coefficient bytes.
module filter_bank #(
  parameter int          AUDIO_BDEPTH = 8,
  parameter int          FILTER_COUNT = 4,
  parameter logic [15:0] BASE_ADDRESS = 16'h0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [15:0]             adr_i,
  input  logic [7:0]              dat_i,
  output logic [7:0]              dat_o,
  input  logic                    we_i,
  input  logic                    sel_i,
  input  logic                    stb_i,
  input  logic                    cyc_i,
  output logic                    ack_o,
  input  logic [2:0]              cti_i,
  input  logic [AUDIO_BDEPTH-1:0] audio_in,
  input  logic                    valid_in,
  output logic [AUDIO_BDEPTH-1:0] audio_out,
  output logic                    valid_out
);

  localparam int W  = AUDIO_BDEPTH + 16;
  localparam int SW = (FILTER_COUNT > 1) ? $clog2(FILTER_COUNT) : 1;
  localparam logic [15:0] COEF_END = 16'(2 + 2 * FILTER_COUNT);
`ifdef FILTER_BANK_PEAK_EN
  localparam logic [15:0] WIN = COEF_END + 16'd1;
`else
  localparam logic [15:0] WIN = COEF_END;
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} fsm_t;

  fsm_t                   fsm_r, fsm_nx_s;
  logic                   ack_r;
  logic [7:0]             dat_r;
  logic                   en_r;
  logic [15:0]            coef_r [FILTER_COUNT];
  logic signed [W-1:0]    st_r [FILTER_COUNT];
  logic [SW-1:0]          stage_r;
  logic signed [W-1:0]    x_r;
  logic [AUDIO_BDEPTH-1:0] audio_out_r;
  logic                   valid_out_r;

  logic [15:0]            off_s;
  logic                   in_range_s, req_s, wr_s, rd_s, clr_s, coef_wr_s;
  logic [SW-1:0]          sel_idx_s;
  logic [7:0]             rd_data_s;
  logic                   cap_s, byp_s, upd_s, last_s;
  logic signed [W-1:0]    y_cur_s, new_y_s;
  logic [16:0]            alpha_s;
  logic signed [W:0]      diff_s;
  logic signed [W+18:0]   prod_s, sh_s;
  logic                   unused_s;

  // Magnitude of a signed sample, saturating the most negative code to the most positive one.
  function automatic logic [AUDIO_BDEPTH-1:0] abs_sat(input logic [AUDIO_BDEPTH-1:0] v);
    if (v == {1'b1, {(AUDIO_BDEPTH-1){1'b0}}}) begin
      abs_sat = {1'b0, {(AUDIO_BDEPTH-1){1'b1}}};
    end else if (v[AUDIO_BDEPTH-1]) begin
      abs_sat = -v;
    end else begin
      abs_sat = v;
    end
  endfunction

  assign off_s      = adr_i - BASE_ADDRESS;
  assign in_range_s = (off_s < WIN);
  assign req_s      = cyc_i & in_range_s & ~ack_r;
  assign wr_s       = req_s & we_i & sel_i;
  assign rd_s       = req_s & ~we_i;
  assign clr_s      = wr_s & (off_s == 16'd0) & dat_i[1];
  assign coef_wr_s  = wr_s & (off_s >= 16'd2) & (off_s < COEF_END);
  // Offsets 2+2i and 3+2i both map to coefficient i.
  assign sel_idx_s  = SW'((off_s >> 1) - 16'd1);

`ifdef FILTER_BANK_PEAK_EN
  logic [AUDIO_BDEPTH-1:0] peak_r;
  logic [AUDIO_BDEPTH-1:0] peak_base_s, out_abs_s;
`endif

  // Register-window read multiplexer.
  always_comb begin
    rd_data_s = 8'h00;
    if (off_s == 16'd0) begin
      rd_data_s = {7'b0, en_r};
    end else if (off_s == 16'd1) begin
      rd_data_s = 8'(FILTER_COUNT);
`ifdef FILTER_BANK_PEAK_EN
    end else if (off_s == COEF_END) begin
      rd_data_s = 8'(peak_r);
`endif
    end else if (off_s[0]) begin
      rd_data_s = coef_r[sel_idx_s][15:8];
    end else begin
      rd_data_s = coef_r[sel_idx_s][7:0];
    end
  end

  // Bus handshake: ack on alternate cycles of a held request, read data registered with it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_r <= 1'b0;
      dat_r <= 8'h00;
    end else begin
      ack_r <= req_s;
      dat_r <= rd_s ? rd_data_s : 8'h00;
    end
  end

  // Control and coefficient registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      en_r <= 1'b1;
      for (int i = 0; i < FILTER_COUNT; i++) coef_r[i] <= 16'hFFFF;
    end else begin
      if (wr_s && (off_s == 16'd0)) en_r <= dat_i[0];
      if (coef_wr_s) begin
        if (off_s[0]) coef_r[sel_idx_s][15:8] <= dat_i;
        else          coef_r[sel_idx_s][7:0]  <= dat_i;
      end
    end
  end

  // Shared multiply: y + floor((x - y) * alpha / 2^16) for the stage selected by stage_r.
  assign y_cur_s = st_r[stage_r];
  assign alpha_s = {1'b0, coef_r[stage_r]} + 17'd1;
  assign diff_s  = {x_r[W-1], x_r} - {y_cur_s[W-1], y_cur_s};
  assign prod_s  = diff_s * $signed({1'b0, alpha_s});
  assign sh_s    = prod_s >>> 16;
  assign new_y_s = y_cur_s + sh_s[W-1:0];

  // Sequencer state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) fsm_r <= IDLE;
    else        fsm_r <= fsm_nx_s;
  end

  // Sequencer next state.
  always_comb begin
    fsm_nx_s = fsm_r;
    case (fsm_r)
      IDLE:    fsm_nx_s = (valid_in && en_r) ? RUN : IDLE;
      RUN:     fsm_nx_s = last_s ? IDLE : RUN;
      default: fsm_nx_s = IDLE;
    endcase
  end

  // Sequencer control strobes.
  always_comb begin
    cap_s  = 1'b0;
    byp_s  = 1'b0;
    upd_s  = 1'b0;
    last_s = 1'b0;
    case (fsm_r)
      IDLE: begin
        cap_s = valid_in & en_r;
        byp_s = valid_in & ~en_r;
      end
      RUN: begin
        upd_s  = 1'b1;
        last_s = (stage_r == SW'(FILTER_COUNT - 1));
      end
      default: begin
        cap_s = 1'b0;
      end
    endcase
  end

  // Stage pointer and carried full-precision stage input.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stage_r <= '0;
      x_r     <= '0;
    end else if (cap_s) begin
      stage_r <= '0;
      x_r     <= {audio_in, 16'h0000};
    end else if (upd_s) begin
      stage_r <= stage_r + SW'(1);
      x_r     <= new_y_s;
    end
  end

  // Stage states; a clear overrides the update landing on the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < FILTER_COUNT; i++) st_r[i] <= '0;
    end else if (clr_s) begin
      for (int i = 0; i < FILTER_COUNT; i++) st_r[i] <= '0;
    end else if (upd_s) begin
      st_r[stage_r] <= new_y_s;
    end
  end

  // Output sample register and strobe.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      audio_out_r <= '0;
      valid_out_r <= 1'b0;
    end else begin
      valid_out_r <= last_s | byp_s;
      if (byp_s)       audio_out_r <= audio_in;
      else if (last_s) audio_out_r <= new_y_s[W-1:16];
    end
  end

`ifdef FILTER_BANK_PEAK_EN
  assign peak_base_s = (rd_s && (off_s == COEF_END)) ? '0 : peak_r;
  assign out_abs_s   = abs_sat(byp_s ? audio_in : new_y_s[W-1:16]);

  // Peak magnitude tracker, cleared when read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      peak_r <= '0;
    end else if ((byp_s || last_s) && (out_abs_s > peak_base_s)) begin
      peak_r <= out_abs_s;
    end else begin
      peak_r <= peak_base_s;
    end
  end
`endif

  assign unused_s  = ^{stb_i, cti_i, sh_s[W+18:W]};
  assign ack_o     = ack_r;
  assign dat_o     = dat_r;
  assign audio_out = audio_out_r;
  assign valid_out = valid_out_r;

endmodule

// File: tb/tb_filter_bank.sv
// Directed self-checking bench for filter_bank (FILTER_COUNT=4, 8-bit audio).
module tb_filter_bank;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [15:0] adr_i = 16'h0000;
  logic [7:0]  dat_i = 8'h00;
  logic [7:0]  dat_o;
  logic        we_i = 1'b0;
  logic        sel_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic        ack_o;
  logic [2:0]  cti_i = 3'b000;
  logic [7:0]  audio_in = 8'h00;
  logic        valid_in = 1'b0;
  logic [7:0]  audio_out;
  logic        valid_out;

  int total = 0;
  int bad = 0;

  filter_bank #(.AUDIO_BDEPTH(8), .FILTER_COUNT(4), .BASE_ADDRESS(16'h0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o),
    .cti_i(cti_i), .audio_in(audio_in), .valid_in(valid_in),
    .audio_out(audio_out), .valid_out(valid_out)
  );

  always #5 clk_i = ~clk_i;

  // Holds cyc_i for 'hold' clocks, counting acks and keeping the last acked read data.
  task automatic bus_access(input logic [15:0] a, input logic w, input logic [7:0] d,
                            input int hold, output int acks, output logic [7:0] rdat);
    @(negedge clk_i);
    adr_i = a; we_i = w; dat_i = d; sel_i = 1'b1; cyc_i = 1'b1;
    acks = 0; rdat = 8'h00;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk_i); #1;
      if (ack_o) begin
        acks++;
        rdat = dat_o;
      end
    end
    @(negedge clk_i);
    cyc_i = 1'b0; we_i = 1'b0; sel_i = 1'b0;
  endtask

  // One valid_in pulse; lat = clocks until valid_out (-1 if none in 20).
  task automatic send_sample(input logic [7:0] s, output int lat, output logic [7:0] o);
    @(negedge clk_i);
    audio_in = s; valid_in = 1'b1; lat = -1; o = 8'h00;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk_i); #1;
      valid_in = 1'b0;
      if (valid_out && lat < 0) begin
        lat = n;
        o = audio_out;
      end
    end
  endtask

  task automatic test_reset();
    int acks; logic [7:0] d;
    logic [15:0] noack_off;
    logic [7:0] exp_rd [4];
    logic [15:0] rd_off [4];
    rd_off = '{16'd1, 16'd2, 16'd3, 16'd0};
    exp_rd = '{8'h04, 8'hFF, 8'hFF, 8'h01};
`ifdef FILTER_BANK_PEAK_EN
    noack_off = 16'd11;
`else
    noack_off = 16'd10;
`endif
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    total++; if (ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ack_o); end
    total++; if (dat_o !== 8'h00) begin bad++; $display("FAIL reset_dat got=%h exp=00", dat_o); end
    total++; if (audio_out !== 8'h00) begin bad++; $display("FAIL reset_audio got=%h exp=00", audio_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    @(negedge clk_i); rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_access(rd_off[i], 1'b0, 8'h00, 1, acks, d);
      total++;
      if (acks !== 1 || d !== exp_rd[i]) begin
        bad++; $display("FAIL reset_read off=%0d got=%h acks=%0d exp=%h", rd_off[i], d, acks, exp_rd[i]);
      end
    end
    bus_access(noack_off, 1'b0, 8'h00, 4, acks, d);
    total++; if (acks !== 0) begin bad++; $display("FAIL out_of_range acks got=%0d exp=0", acks); end
  endtask

  task automatic test_passthrough();
    int lat; logic [7:0] o;
    send_sample(8'h05, lat, o);
    total++; if (lat !== 5) begin bad++; $display("FAIL pass_latency got=%0d exp=5", lat); end
    total++; if (o !== 8'h05) begin bad++; $display("FAIL pass_value got=%h exp=05", o); end
  endtask

  task automatic test_coef_write();
    int acks; logic [7:0] d;
    bus_access(16'd0, 1'b1, 8'h03, 2, acks, d);
    bus_access(16'd2, 1'b1, 8'hFF, 2, acks, d);
    total++; if (acks !== 1) begin bad++; $display("FAIL coef_lo_acks got=%0d exp=1", acks); end
    bus_access(16'd3, 1'b1, 8'h3F, 2, acks, d);
    total++; if (acks !== 1) begin bad++; $display("FAIL coef_hi_acks got=%0d exp=1", acks); end
    bus_access(16'd2, 1'b0, 8'h00, 1, acks, d);
    total++; if (d !== 8'hFF) begin bad++; $display("FAIL coef_lo_read got=%h exp=ff", d); end
    bus_access(16'd3, 1'b0, 8'h00, 1, acks, d);
    total++; if (d !== 8'h3F) begin bad++; $display("FAIL coef_hi_read got=%h exp=3f", d); end
  endtask

  task automatic test_filter();
    int lat; logic [7:0] o; int acks; logic [7:0] d;
    logic [7:0] exp_o [3];
    exp_o = '{8'd16, 8'd28, 8'd37};
    for (int i = 0; i < 3; i++) begin
      send_sample(8'd64, lat, o);
      total++;
      if (o !== exp_o[i] || lat !== 5) begin
        bad++; $display("FAIL filter_step%0d got=%h lat=%0d exp=%h", i, o, lat, exp_o[i]);
      end
    end
    bus_access(16'd0, 1'b1, 8'h03, 2, acks, d);
    bus_access(16'd0, 1'b0, 8'h00, 1, acks, d);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL ctrl_after_clear got=%h exp=01", d); end
    send_sample(8'hC0, lat, o);
    total++; if (o !== 8'hF0) begin bad++; $display("FAIL filter_cleared got=%h exp=f0", o); end
  endtask

  task automatic test_bypass();
    int lat; logic [7:0] o; int acks; logic [7:0] d;
    bus_access(16'd0, 1'b1, 8'h00, 2, acks, d);
    send_sample(8'h9C, lat, o);
    total++; if (lat !== 1) begin bad++; $display("FAIL bypass_latency got=%0d exp=1", lat); end
    total++; if (o !== 8'h9C) begin bad++; $display("FAIL bypass_value got=%h exp=9c", o); end
    bus_access(16'd0, 1'b1, 8'h01, 2, acks, d);
    send_sample(8'hC0, lat, o);
    total++; if (o !== 8'hE4) begin bad++; $display("FAIL bypass_state_hold got=%h exp=e4", o); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0; int lat = -1; logic [7:0] o = 8'h00;
    @(negedge clk_i);
    audio_in = 8'h24; valid_in = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk_i); #1;
      valid_in = (n == 2);
      if (n == 2) audio_in = 8'h7F;
      if (valid_out) begin
        pulses++;
        if (lat < 0) begin lat = n; o = audio_out; end
      end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL drop_pulses got=%0d exp=1", pulses); end
    total++; if (o !== 8'hF4 || lat !== 5) begin bad++; $display("FAIL drop_value got=%h lat=%0d exp=f4 lat=5", o, lat); end
  endtask

`ifdef FILTER_BANK_PEAK_EN
  task automatic test_peak();
    int lat; logic [7:0] o; int acks; logic [7:0] d;
    logic [7:0] seq [3];
    seq = '{8'd10, 8'hCE, 8'd20};
    bus_access(16'd3, 1'b1, 8'hFF, 2, acks, d);
    bus_access(16'd10, 1'b0, 8'h00, 1, acks, d);
    for (int i = 0; i < 3; i++) send_sample(seq[i], lat, o);
    bus_access(16'd10, 1'b0, 8'h00, 1, acks, d);
    total++; if (d !== 8'd50) begin bad++; $display("FAIL peak_value got=%0d exp=50", d); end
    bus_access(16'd10, 1'b0, 8'h00, 1, acks, d);
    total++; if (d !== 8'd0) begin bad++; $display("FAIL peak_cleared got=%0d exp=0", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_coef_write();
    test_filter();
    test_bypass();
    test_back_to_back();
`ifdef FILTER_BANK_PEAK_EN
    test_peak();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
